// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF sync, debounce FSM, level/press/release/long strobes, press counter.
// Latency: a stable level change appears DEBOUNCE_CYCLES+3 edges after the raw input moves.
// Backpressure: none; strobes are single-cycle and must be consumed on the cycle they appear.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn,
  output logic             btn_level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic [CNT_W-1:0] press_count
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               s1_q, btn_sync;
  logic [DB_W-1:0]    db_q, db_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               level_q, level_d;
  logic               press_q, press_d;
  logic               rel_q, rel_d;
  logic               long_q, long_d;
  logic               hold_run;

  // Only btn_sync may be used past this point; s1_q can be metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      s1_q     <= btn;
      btn_sync <= s1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      db_q    <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    db_d     = db_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    long_d   = 1'b0;
    hold_run = 1'b0;

    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d = PRESS_WAIT;
          db_d    = '0;
        end
      end

      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = IDLE;
          db_d    = '0;
        end else if (db_q == DB_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          hold_d  = '0;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end

      PRESSED: begin
        hold_run = 1'b1;
        if (!btn_sync) begin
          state_d = RELEASE_WAIT;
          db_d    = '0;
        end
      end

      RELEASE_WAIT: begin
        // A release bounce returns to PRESSED without disturbing the hold timer.
        hold_run = 1'b1;
        if (btn_sync) begin
          state_d = PRESSED;
          db_d    = '0;
        end else if (db_q == DB_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        db_d    = '0;
      end
    endcase

    // Saturation at HOLD_MAX is what limits long_pulse to once per press.
    if (hold_run && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HOLD_W'(1);
      long_d = (hold_q == HOLD_PRE);
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;
  assign press_count   = cnt_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboarded bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_btn_debounce;

  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int LAT  = DB + 3;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LONG),
    .CNT_W          (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn          (btn),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count)
  );

  typedef struct {
    int kind;   // 0 press, 1 release, 2 long
    int cyc;
    int cnt;
    int lvl;
  } ev_t;

  ev_t q[$];
  int  cyc     = 0;
  int  npass   = 0;
  int  ntot    = 0;
  int  exp_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int kind, input int at, input int cnt, input int lvl);
    ev_t e;
    e.kind = kind; e.cyc = at; e.cnt = cnt; e.lvl = lvl;
    q.push_back(e);
  endtask

  task automatic take(input int kind);
    ev_t e;
    if (q.size() == 0) begin
      ntot++;
      $display("FAIL unexpected_pulse: got kind %0d, expected none (cycle %0d)", kind, cyc);
    end else begin
      e = q.pop_front();
      chk("pulse_kind", kind, e.kind);
      chk("pulse_cycle", cyc, e.cyc);
      chk("pulse_count", int'(press_count), e.cnt);
      chk("pulse_level", int'(btn_level), e.lvl);
    end
  endtask

  // Monitor: every observed strobe must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (press_pulse)   take(0);
      if (release_pulse) take(1);
      if (long_pulse)    take(2);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        ntot++;
        $display("FAIL missing_pulse: got none, expected kind %0d at cycle %0d", q[0].kind, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_cyc(2);
    exp_cnt = 0;
    chk("reset_count", int'(press_count), 0);
    rst_n = 1'b1;
    wait_cyc(5);
  endtask

  // Clean press of `hold` cycles, scheduling the expected strobes.
  task automatic press(input int hold, input bit with_long);
    int t;
    t = cyc;
    btn = 1'b1;
    exp_cnt = (exp_cnt + 1) % 256;
    push(0, t + LAT, exp_cnt, 1);
    if (with_long) push(2, t + LAT + LONG, exp_cnt, 1);
    wait_cyc(hold);
    btn = 1'b0;
    push(1, t + hold + LAT, exp_cnt, 0);
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    btn   = 1'b0;
    @(negedge clk);

    // 1: reset with bouncing input, then idle
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      wait_cyc(1);
      chk("rst_outputs", int'({btn_level, press_pulse, release_pulse, long_pulse}), 0);
      chk("rst_count", int'(press_count), 0);
    end
    btn = 1'b0;
    rst_n = 1'b1;
    wait_cyc(50);
    chk("idle_level", int'(btn_level), 0);
    chk("idle_count", int'(press_count), 0);

    // 2: clean long press
    press(100, 1'b1);
    wait_cyc(20);
    chk("clean_count", int'(press_count), 1);

    // 3: bounce then settle
    for (int i = 0; i < 8; i++) begin
      btn = 1'b1; wait_cyc(2);
      btn = 1'b0; wait_cyc(2);
    end
    press(15, 1'b0);
    wait_cyc(20);
    chk("bounce_count", int'(press_count), 2);

    // 4: release bounce while pressed; long timing unchanged
    t = cyc;
    btn = 1'b1;
    exp_cnt = 3;
    push(0, t + LAT, 3, 1);
    push(2, t + LAT + LONG, 3, 1);
    wait_cyc(12);
    btn = 1'b0;
    wait_cyc(2);
    btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_cyc(1);
      chk("glitch_level", int'(btn_level), 1);
    end
    wait_cyc(t + 60 - cyc);
    btn = 1'b0;
    push(1, t + 60 + LAT, 3, 0);
    wait_cyc(20);
    chk("glitch_level_low", int'(btn_level), 0);

    // 5: counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) begin
      press(10, 1'b0);
      wait_cyc(10);
    end
    wait_cyc(20);
    chk("wrap_count", int'(press_count), 0);

    // 6: reset mid-press
    do_reset();
    t = cyc;
    btn = 1'b1;
    push(0, t + LAT, 1, 1);
    wait_cyc(12);
    chk("mid_level", int'(btn_level), 1);
    rst_n = 1'b0;
    wait_cyc(3);
    chk("mid_rst_count", int'(press_count), 0);
    chk("mid_rst_level", int'(btn_level), 0);
    t = cyc;
    rst_n = 1'b1;
    exp_cnt = 0;
    exp_cnt = 1;
    push(0, t + LAT, 1, 1);
    wait_cyc(15);
    btn = 1'b0;
    push(1, cyc + LAT, 1, 0);
    wait_cyc(25);
    chk("mid_final_count", int'(press_count), 1);

    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
